// File: rtl/tanh_inv_search_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tanh_inv_search_4bit
// Purpose  : Sequential inverse of the 4-bit approximate tanh mapping. For a
//            target output code y, every input code x = 0..15 is evaluated
//            one per cycle through the forward mapping f(x). The block
//            returns the best-matching x, its error |f(x) - y| and the number
//            of exact preimages.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req_valid  - request present          (in)
//            req_ready  - request accepted, IDLE   (out)
//            req_code   - target output code y     (in, 4b)
//            rsp_valid  - response present, DONE   (out)
//            rsp_ready  - consumer takes response  (in)
//            rsp_x      - selected input code      (out, 4b)
//            rsp_err    - |f(rsp_x) - y|           (out, 4b)
//            rsp_exact  - rsp_err == 0             (out)
//            rsp_count  - number of exact x        (out, 5b, 0..16)
// Params   : PREFER_HIGH - 0 keeps lowest x on error ties, 1 keeps highest
// Revision : 1.0 - initial release
// ============================================================================
module tanh_inv_search_4bit #(
    parameter logic PREFER_HIGH = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_code,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_x,
    output logic [3:0] rsp_err,
    output logic       rsp_exact,
    output logic [4:0] rsp_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] y_q;
    logic [3:0] idx_q;
    logic [3:0] best_x_q;
    logic [3:0] best_err_q;
    logic [4:0] count_q;

    logic       req_ready_q;
    logic       rsp_valid_q;
    logic [3:0] rsp_x_q;
    logic [3:0] rsp_err_q;
    logic       rsp_exact_q;
    logic [4:0] rsp_count_q;

    // ------------------------------------------------------------------
    // Candidate evaluation for the current scan index
    // ------------------------------------------------------------------
    logic       w_a;
    logic [3:0] w_f;
    logic [4:0] w_diff;
    logic [3:0] w_d;
    logic       w_take;
    logic [3:0] best_x_d;
    logic [3:0] best_err_d;
    logic [4:0] count_d;

    assign w_a = idx_q[1] & ~(idx_q[0] & ~idx_q[3]);
    assign w_f = {w_a, (idx_q[2] & idx_q[1]) | w_a, idx_q[0], idx_q[0]};

    // 5-bit two's-complement difference; magnitude never exceeds 15, so the
    // low nibble of the negated value is the exact absolute error.
    assign w_diff = {1'b0, w_f} - {1'b0, y_q};
    assign w_d    = w_diff[4] ? (~w_diff[3:0] + 4'd1) : w_diff[3:0];

    // Ascending scan: strict compare keeps the first (lowest) tie, non-strict
    // lets later (higher) ties overwrite.
    assign w_take     = PREFER_HIGH ? (w_d <= best_err_q) : (w_d < best_err_q);
    assign best_x_d   = w_take ? idx_q : best_x_q;
    assign best_err_d = w_take ? w_d   : best_err_q;
    assign count_d    = count_q + {4'd0, (w_d == 4'd0)};

    // ------------------------------------------------------------------
    // Control FSM with registered handshake and response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_q         <= 4'd0;
            idx_q       <= 4'd0;
            best_x_q    <= 4'd0;
            best_err_q  <= 4'hF;
            count_q     <= 5'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_x_q     <= 4'd0;
            rsp_err_q   <= 4'd0;
            rsp_exact_q <= 1'b0;
            rsp_count_q <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        y_q         <= req_code;
                        idx_q       <= 4'd0;
                        best_x_q    <= 4'd0;
                        best_err_q  <= 4'hF;
                        count_q     <= 5'd0;
                        req_ready_q <= 1'b0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    best_x_q   <= best_x_d;
                    best_err_q <= best_err_d;
                    count_q    <= count_d;
                    if (idx_q == 4'd15) begin
                        // Last candidate: publish the updated result directly
                        rsp_x_q     <= best_x_d;
                        rsp_err_q   <= best_err_d;
                        rsp_exact_q <= (best_err_d == 4'd0);
                        rsp_count_q <= count_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_exact = rsp_exact_q;
    assign rsp_count = rsp_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tanh_inv_search_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_tanh_inv_search_4bit
// Purpose  : Self-checking bench for tanh_inv_search_4bit. Two instances
//            (low- and high-preference tie-break) share all inputs; expected
//            responses are queued on accept and compared when rsp_valid rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tanh_inv_search_4bit;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x_lo;
        logic [3:0] x_hi;
        logic [3:0] err;
        logic [4:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [3:0] req_code;
    logic       rsp_ready;

    logic       req_ready_lo, rsp_valid_lo, rsp_exact_lo;
    logic [3:0] rsp_x_lo, rsp_err_lo;
    logic [4:0] rsp_count_lo;
    logic       req_ready_hi, rsp_valid_hi, rsp_exact_hi;
    logic [3:0] rsp_x_hi, rsp_err_hi;
    logic [4:0] rsp_count_hi;

    logic [27:0] obs;
    assign obs = {rsp_x_lo, rsp_x_hi, rsp_err_lo, rsp_err_hi,
                  rsp_exact_lo, rsp_exact_hi, rsp_count_lo, rsp_count_hi};

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    tanh_inv_search_4bit #(.PREFER_HIGH(1'b0)) u_dut_lo (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_lo), .req_code(req_code),
        .rsp_valid(rsp_valid_lo), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x_lo), .rsp_err(rsp_err_lo),
        .rsp_exact(rsp_exact_lo), .rsp_count(rsp_count_lo)
    );

    tanh_inv_search_4bit #(.PREFER_HIGH(1'b1)) u_dut_hi (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_hi), .req_code(req_code),
        .rsp_valid(rsp_valid_hi), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x_hi), .rsp_err(rsp_err_hi),
        .rsp_exact(rsp_exact_hi), .rsp_count(rsp_count_hi)
    );

    // Forward mapping written from its range table
    function automatic logic [3:0] fref(input logic [3:0] x);
        case (x)
            4'd0, 4'd4, 4'd8, 4'd12:          fref = 4'd0;
            4'd1, 4'd3, 4'd5, 4'd9, 4'd13:    fref = 4'd3;
            4'd7:                             fref = 4'd7;
            4'd2, 4'd6, 4'd10, 4'd14:         fref = 4'd12;
            default:                          fref = 4'd15;
        endcase
    endfunction

    function automatic exp_t model(input logic [3:0] y);
        exp_t r;
        int   e;
        int   mn;
        r     = '0;
        r.y   = y;
        mn    = 99;
        for (int x = 0; x < 16; x++) begin
            e = int'(fref(4'(x))) - int'(y);
            if (e < 0) e = -e;
            if (e < mn) begin
                mn     = e;
                r.x_lo = 4'(x);
            end
            if (e <= mn) r.x_hi = 4'(x);
            if (e == 0) r.cnt = r.cnt + 5'd1;
        end
        r.err = 4'(mn);
        return r;
    endfunction

    // Hand-derived expectations for the directed codes
    function automatic exp_t dir_exp(input int i);
        case (i)
            0:       dir_exp = {4'd3,  4'd1,  4'd13, 4'd0, 5'd5};
            1:       dir_exp = {4'd7,  4'd7,  4'd7,  4'd0, 5'd1};
            2:       dir_exp = {4'd15, 4'd11, 4'd15, 4'd0, 5'd2};
            3:       dir_exp = {4'd0,  4'd0,  4'd12, 4'd0, 5'd4};
            4:       dir_exp = {4'd5,  4'd1,  4'd13, 4'd2, 5'd0};
            5:       dir_exp = {4'd9,  4'd7,  4'd7,  4'd2, 5'd0};
            default: dir_exp = {4'd10, 4'd2,  4'd14, 4'd2, 5'd0};
        endcase
    endfunction

    function automatic logic [27:0] pack(input exp_t e);
        pack = {e.x_lo, e.x_hi, e.err, e.err,
                (e.err == 4'd0), (e.err == 4'd0), e.cnt, e.cnt};
    endfunction

    // Offer a request until accepted; queues the expectation at the accept edge
    task automatic do_req(input exp_t e, output bit ok);
        ok        = 1'b0;
        req_code  = e.y;
        req_valid = 1'b1;
        for (int c = 0; c < 64; c++) begin
            if (req_ready_lo) begin
                @(posedge clk);
                ok = 1'b1;
                sb.push_back(e);
                break;
            end
            @(posedge clk);
            #1;
        end
        #1;
        req_valid = 1'b0;
    endtask

    // Count edges from the accept edge until rsp_valid is seen (bounded)
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid_lo) break;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_code  = 4'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready_lo, rsp_valid_lo, req_ready_hi, rsp_valid_hi, obs} !== {4'b1010, 28'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h",
                     {req_ready_lo, rsp_valid_lo, req_ready_hi, rsp_valid_hi, obs}, {4'b1010, 28'd0});
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready_lo, rsp_valid_lo} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 10", {req_ready_lo, rsp_valid_lo});
        end
    endtask

    task automatic test_directed;
        bit   ok;
        int   lat;
        exp_t ee;
        for (int i = 0; i < 7; i++) begin
            do_req(dir_exp(i), ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL dir_accept y=%0d: got not accepted expected accepted", dir_exp(i).y);
            end
            wait_valid(lat);
            n_checks++;
            if (lat !== 16 || !rsp_valid_lo) begin
                n_fail++;
                $display("FAIL dir_latency y=%0d: got %0d cycles expected 16", dir_exp(i).y, lat);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL dir_rsp: got response with empty scoreboard expected entry");
            end else begin
                ee = sb.pop_front();
                if (obs !== pack(ee)) begin
                    n_fail++;
                    $display("FAIL dir_rsp y=%0d: got %h expected %h", ee.y, obs, pack(ee));
                end
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            n_checks++;
            if ({rsp_valid_lo, req_ready_lo, rsp_valid_hi, req_ready_hi} !== 4'b0101) begin
                n_fail++;
                $display("FAIL dir_handshake: got %b expected 0101",
                         {rsp_valid_lo, req_ready_lo, rsp_valid_hi, req_ready_hi});
            end
        end
    endtask

    task automatic test_reset_busy;
        bit ok;
        int lat;
        bit seen;
        // Reset in the middle of a scan
        do_req(dir_exp(2), ok);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready_lo, rsp_valid_lo, req_ready_hi, rsp_valid_hi, obs} !== {4'b1010, 28'd0}) begin
            n_fail++;
            $display("FAIL reset_in_scan: got %h expected %h",
                     {req_ready_lo, rsp_valid_lo, req_ready_hi, rsp_valid_hi, obs}, {4'b1010, 28'd0});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            seen = seen | rsp_valid_lo | rsp_valid_hi;
        end
        n_checks++;
        if (seen || !req_ready_lo) begin
            n_fail++;
            $display("FAIL dropped_request: got rsp_seen=%0b req_ready=%0b expected 0 1", seen, req_ready_lo);
        end
        // Reset while holding a response
        do_req(dir_exp(2), ok);
        wait_valid(lat);
        n_checks++;
        if (!rsp_valid_lo || rsp_x_lo !== 4'd11) begin
            n_fail++;
            $display("FAIL pre_reset_done: got valid=%0b x=%0d expected 1 11", rsp_valid_lo, rsp_x_lo);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready_lo, rsp_valid_lo, req_ready_hi, rsp_valid_hi, obs} !== {4'b1010, 28'd0}) begin
            n_fail++;
            $display("FAIL reset_in_done: got %h expected %h",
                     {req_ready_lo, rsp_valid_lo, req_ready_hi, rsp_valid_hi, obs}, {4'b1010, 28'd0});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        bit   ok;
        int   lat;
        exp_t ee;
        ee = '0;
        do_req(dir_exp(5), ok);
        wait_valid(lat);
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL bp_rsp: got response with empty scoreboard expected entry");
        end else begin
            ee = sb.pop_front();
            if (obs !== pack(ee) || !rsp_valid_lo) begin
                n_fail++;
                $display("FAIL bp_rsp y=%0d: got %h expected %h", ee.y, obs, pack(ee));
            end
        end
        // Pending request offered while the response is stalled
        req_code  = 4'd7;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({obs, rsp_valid_lo, req_ready_lo} !== {pack(ee), 2'b10}) begin
                n_fail++;
                $display("FAIL bp_stall cycle %0d: got %h expected %h",
                         c, {obs, rsp_valid_lo, req_ready_lo}, {pack(ee), 2'b10});
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid_lo, req_ready_lo} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: got %b expected 01", {rsp_valid_lo, req_ready_lo});
        end
        @(posedge clk);
        sb.push_back(dir_exp(1));
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (req_ready_lo !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pending_accept: got req_ready=%0b expected 0", req_ready_lo);
        end
        wait_valid(lat);
        n_checks++;
        if (lat !== 16 || !rsp_valid_lo) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d cycles expected 16", lat);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL bp_pending_rsp: got response with empty scoreboard expected entry");
        end else begin
            ee = sb.pop_front();
            if (obs !== pack(ee)) begin
                n_fail++;
                $display("FAIL bp_pending_rsp y=%0d: got %h expected %h", ee.y, obs, pack(ee));
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit         ok;
        int         lat;
        exp_t       ee;
        logic [3:0] y;
        for (int i = 0; i < 16; i++) begin
            y = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_req(model(y), ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL b2b_accept y=%0d: got not accepted expected accepted", y);
            end
            wait_valid(lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_rsp: got response with empty scoreboard expected entry");
            end else begin
                ee = sb.pop_front();
                if ({rsp_valid_lo, obs} !== {1'b1, pack(ee)}) begin
                    n_fail++;
                    $display("FAIL b2b_rsp y=%0d: got %h expected %h",
                             ee.y, {rsp_valid_lo, obs}, {1'b1, pack(ee)});
                end
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            n_checks++;
            if ({rsp_valid_lo, req_ready_lo, rsp_valid_hi, req_ready_hi} !== 4'b0101) begin
                n_fail++;
                $display("FAIL b2b_handshake: got %b expected 0101",
                         {rsp_valid_lo, req_ready_lo, rsp_valid_hi, req_ready_hi});
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_busy();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/tanh_inv_search_4bit.md
# tanh_inv_search_4bit

Sequential inverse for the 4-bit approximate tanh mapping used by the 4-bit activation circuits. Given a 4-bit output code y, the block scans all 16 input codes x, evaluating the forward mapping f(x) once per cycle. It returns:
- a preimage x (exact match, or nearest code when none exists);
- the match error;
- the number of exact preimages.

It sits behind the activation stage, where it recovers pre-activation codes from activation outputs during characterization and back-propagation experiments.

## Interface
- PREFER_HIGH, default 0, tie-break rule: 0 keeps the lowest x among equal-error candidates, 1 keeps the highest x.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_code  input  4  target output code y.
- rsp_valid  output  1  response present; high only in DONE.
- rsp_ready  input  1  consumer accepts the response.
- rsp_x  output  4  selected input code.
- rsp_err  output  4  |f(rsp_x) − y|, unsigned.
- rsp_exact  output  1  1 when rsp_err == 0.
- rsp_count  output  5  number of x in 0..15 with f(x) == y (range 0..16).

## Operation
- Forward mapping f, with x = x3x2x1x0:
  - a = x1 & ~(x0 & ~x3);
  - f = {a, (x2 & x1) | a, x0, x0}.
- Range of f:
  - f = 0 for x ∈ {0,4,8,12};
  - f = 3 for x ∈ {1,3,5,9,13};
  - f = 7 for x = 7;
  - f = 12 for x ∈ {2,6,10,14};
  - f = 15 for x ∈ {11,15}.
- States: IDLE → SCAN → DONE → IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch y, set idx = 0, best_err = 15, best_x = 0, count = 0, then go to SCAN.
- SCAN, one candidate per cycle, idx = 0..15 ascending:
  - d = |f(idx) − y|, computed as a 5-bit signed difference reduced to 4-bit magnitude.
  - Update best_x/best_err when d < best_err (PREFER_HIGH = 0) or d <= best_err (PREFER_HIGH = 1). The initial best_err = 15 is always overwritten at idx 0 unless d = 15, in which case x = 0 is kept.
  - count increments when d == 0.
  - After idx = 15 is evaluated, go to DONE. idx does not wrap; there is no early exit.
- DONE:
  - rsp_* are driven from registers and held stable while rsp_valid & ~rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
- req_valid and req_code are ignored outside IDLE. A request asserted during SCAN/DONE stays pending and is accepted once IDLE is reached.

## Timing
- Reset (asynchronous assert; deassert synchronized externally): state = IDLE, req_ready = 1, rsp_valid = 0, rsp_x = 0, rsp_err = 0, rsp_exact = 0, rsp_count = 0.
- Accept at edge E0. SCAN evaluates idx k at edge E(k+1). rsp_valid rises after E16, i.e. latency is 16 cycles from accept.
- Response handshake at edge H: rsp_valid = 0 and req_ready = 1 after H. The next request can be accepted at H+1. Throughput is 1 request per 18 cycles minimum.
- Response fields keep their last values in IDLE; they are only meaningful while rsp_valid = 1.
- Reset asserted mid-SCAN or mid-DONE: immediate return to IDLE with reset values. The in-flight request is dropped and no response is produced.
- req_ready and rsp_valid are never high together.

## Test plan
- Reset in each state → all outputs at reset values within the same cycle, req_ready = 1.
- y = 3, PREFER_HIGH = 0, rsp_ready held high → rsp_valid 16 cycles after accept, rsp_x = 1, rsp_err = 0, rsp_exact = 1, rsp_count = 5. With PREFER_HIGH = 1 → rsp_x = 13.
- y = 7 → rsp_x = 7, count = 1. y = 15 → rsp_x = 11, count = 2. y = 0 → rsp_x = 0, count = 4.
- Non-range codes:
  - y = 5 → rsp_x = 1, rsp_err = 2, exact = 0, count = 0 (tie with x = 7 resolved low).
  - y = 9 → rsp_x = 7, err = 2.
  - y = 10 → rsp_x = 2, err = 2.
- Backpressure: rsp_ready low for 5 cycles in DONE → outputs stable, req_ready = 0, a new req_valid is not accepted. Release → IDLE next cycle; the pending request is accepted the following edge.
- Back-to-back: 16 random y with random rsp_ready stalls → each response matches the scoreboard computed from f over 0..15.
